// File: rtl/led_panel_pkg.sv
// led_panel_pkg: scan state encoding, default geometry and pixel field helpers for the LED panel driver
package led_panel_pkg;
    localparam int DEF_COLS      = 16;
    localparam int DEF_SCAN_ROWS = 4;
    localparam int DEF_BPC       = 2;
    localparam int DEF_BASE_ON   = 8;
    localparam int PIX_MAX       = 12;
    localparam int CH_B          = 0;
    localparam int CH_G          = 1;
    localparam int CH_R          = 2;
    typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} state_t;
    // pixels are {r, g, b}, so channel ch occupies bits [ch*bpc +: bpc]
    function automatic logic chan_bit(input logic [PIX_MAX-1:0] pix, input int bpc, input int ch, input int plane);
        logic [PIX_MAX-1:0] s;
        s = pix >> (ch * bpc + plane);
        return s[0];
    endfunction
endpackage

// File: rtl/led_panel_fb.sv
// led_panel_fb: double-buffered pixel store; writes land in the back buffer, reads see the front
module led_panel_fb import led_panel_pkg::*; #(
    parameter int PIX_W = 6,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             toggle,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-2:0]    raddr,
    output logic [PIX_W-1:0] rd_upper,
    output logic [PIX_W-1:0] rd_lower
);
    localparam int DEPTH = 1 << AW;
    logic front, rd_front;
    logic [PIX_W-1:0] st0 [DEPTH];
    logic [PIX_W-1:0] st1 [DEPTH];
    // the read address is for the next cycle, so reads must already see a swap taking effect
    assign rd_front = front ^ toggle;
    assign rd_upper = rd_front ? st1[{1'b0, raddr}] : st0[{1'b0, raddr}];
    assign rd_lower = rd_front ? st1[{1'b1, raddr}] : st0[{1'b1, raddr}];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) front <= 1'b0;
        else if (toggle) front <= ~front;
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_px
        logic [PIX_W-1:0] p0, p1;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                p0 <= '0;
                p1 <= '0;
            end else if (we && waddr == AW'(i)) begin
                if (front) p0 <= wdata;
                else p1 <= wdata;
            end
        end
        assign st0[i] = p0;
        assign st1[i] = p1;
    end
endmodule

// File: rtl/led_panel_bcm.sv
// led_panel_bcm: HUB75 scan driver with binary-coded-modulation planes and tear-free buffer swap
module led_panel_bcm import led_panel_pkg::*; #(
    parameter int COLS      = DEF_COLS,
    parameter int SCAN_ROWS = DEF_SCAN_ROWS,
    parameter int BPC       = DEF_BPC,
    parameter int BASE_ON   = DEF_BASE_ON,
    localparam int COL_W    = $clog2(COLS),
    localparam int ADDR_W   = $clog2(SCAN_ROWS),
    localparam int PIX_W    = 3 * BPC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W+COL_W:0]   wr_addr,
    input  logic [PIX_W-1:0]        wr_data,
    input  logic                    swap_req,
    output logic                    swap_done,
    output logic [1:0]              red,
    output logic [1:0]              green,
    output logic [1:0]              blue,
    output logic                    sclk,
    output logic                    latch,
    output logic                    blank,
    output logic [ADDR_W-1:0]       row_addr
);
    localparam int PL_W  = BPC > 1 ? $clog2(BPC) : 1;
    localparam int CNT_W = $clog2(2 * COLS + (BASE_ON << (BPC - 1)));
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, on_last;
    logic [ADDR_W-1:0] row, row_n;
    logic [PL_W-1:0] plane, plane_n;
    logic frame_end, toggle, shift_n;
    logic [PIX_W-1:0] pix_up, pix_lo;
    int pl;
    assign on_last = (CNT_W'(BASE_ON) << plane) - CNT_W'(1);
    assign toggle  = frame_end & ~wr_ready;
    assign shift_n = state_n == SHIFT;
    assign pl      = int'(plane_n);
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        row_n     = row;
        plane_n   = plane;
        frame_end = 1'b0;
        case (state)
            SHIFT: if (cnt == CNT_W'(2 * COLS - 1)) begin
                state_n = LATCH;
                cnt_n   = '0;
            end
            LATCH: begin
                state_n = DISPLAY;
                cnt_n   = '0;
            end
            default: if (cnt == on_last) begin
                state_n = SHIFT;
                cnt_n   = '0;
                plane_n = (plane == PL_W'(BPC - 1)) ? '0 : plane + PL_W'(1);
                if (plane == PL_W'(BPC - 1)) begin
                    row_n     = row + ADDR_W'(1);
                    frame_end = row == ADDR_W'(SCAN_ROWS - 1);
                end
            end
        endcase
    end
    led_panel_fb #(.PIX_W(PIX_W), .AW(1 + ADDR_W + COL_W)) u_fb (
        .clk      (clk),
        .reset    (reset),
        .toggle   (toggle),
        .we       (wr_valid & wr_ready),
        .waddr    (wr_addr),
        .wdata    (wr_data),
        .raddr    ({row_n, cnt_n[COL_W:1]}),
        .rd_upper (pix_up),
        .rd_lower (pix_lo)
    );
    // outputs are registered from the next-state view so they line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SHIFT;
            cnt       <= '0;
            row       <= '0;
            plane     <= '0;
            wr_ready  <= 1'b1;
            swap_done <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            sclk      <= 1'b0;
            latch     <= 1'b0;
            blank     <= 1'b1;
            row_addr  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            row       <= row_n;
            plane     <= plane_n;
            wr_ready  <= toggle ? 1'b1 : (wr_ready && swap_req) ? 1'b0 : wr_ready;
            swap_done <= toggle;
            red       <= shift_n ? {chan_bit(PIX_MAX'(pix_lo), BPC, CH_R, pl), chan_bit(PIX_MAX'(pix_up), BPC, CH_R, pl)} : 2'b00;
            green     <= shift_n ? {chan_bit(PIX_MAX'(pix_lo), BPC, CH_G, pl), chan_bit(PIX_MAX'(pix_up), BPC, CH_G, pl)} : 2'b00;
            blue      <= shift_n ? {chan_bit(PIX_MAX'(pix_lo), BPC, CH_B, pl), chan_bit(PIX_MAX'(pix_up), BPC, CH_B, pl)} : 2'b00;
            sclk      <= shift_n & cnt_n[0];
            latch     <= state_n == LATCH;
            blank     <= state_n != DISPLAY;
            if (state_n == LATCH) row_addr <= row_n;
        end
    end
endmodule

// File: tb/tb_led_panel_bcm.sv
// tb_led_panel_bcm: randomized bench checking the scan driver against a frame-position reference model
module tb_led_panel_bcm;
    localparam int COLS      = 16;
    localparam int SCAN_ROWS = 4;
    localparam int BPC       = 2;
    localparam int BASE_ON   = 8;
    localparam int PIX_W     = 3 * BPC;
    localparam int DEPTH     = 2 * SCAN_ROWS * COLS;
    localparam int ROW_P     = BPC * (2 * COLS + 1) + BASE_ON * ((1 << BPC) - 1);
    localparam int FRAME     = SCAN_ROWS * ROW_P;
    localparam logic [12:0] RST_OUT = 13'b0000000010010;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic wr_valid = 1'b0;
    logic swap_req = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [PIX_W-1:0] wr_data = '0;
    logic wr_ready, swap_done, sclk, latch, blank;
    logic [1:0] red, green, blue, row_addr;
    logic [12:0] obs, exp_v;
    int passed = 0;
    int total = 0;

    logic [PIX_W-1:0] m_mem [2][DEPTH];
    int m_t;
    logic m_front, m_pend, m_done;

    assign obs = {red, green, blue, sclk, latch, blank, row_addr, wr_ready, swap_done};

    always #5 clk = ~clk;

    led_panel_bcm dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .sclk      (sclk),
        .latch     (latch),
        .blank     (blank),
        .row_addr  (row_addr)
    );

    // reference: frame position counter, two stores, pending flag
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t <= 0;
            m_front <= 1'b0;
            m_pend <= 1'b0;
            m_done <= 1'b0;
            foreach (m_mem[a, b]) m_mem[a][b] <= '0;
        end else begin
            if (wr_valid && !m_pend) m_mem[!m_front][wr_addr] <= wr_data;
            m_done <= (m_t % FRAME == FRAME - 1) && m_pend;
            if ((m_t % FRAME == FRAME - 1) && m_pend) begin
                m_front <= !m_front;
                m_pend <= 1'b0;
            end else if (swap_req) begin
                m_pend <= 1'b1;
            end
            m_t <= m_t + 1;
        end
    end

    function automatic logic pbit(input logic [PIX_W-1:0] px, input int c, input int p);
        logic [PIX_W-1:0] s;
        s = px >> ((2 - c) * BPC + p);
        return s[0];
    endfunction

    function automatic logic [12:0] exp_out();
        int f, row, r, p, col;
        logic [PIX_W-1:0] up, lo;
        logic [1:0] rd, gr, bl, ra;
        logic sc, la, bk;
        f = m_t % FRAME;
        row = f / ROW_P;
        r = f % ROW_P;
        p = 0;
        while (r >= 2 * COLS + 1 + (BASE_ON << p)) begin
            r -= 2 * COLS + 1 + (BASE_ON << p);
            p++;
        end
        {rd, gr, bl, sc, la, bk} = 9'b000000001;
        if (r < 2 * COLS) begin
            col = r / 2;
            sc = 1'(r % 2);
            up = m_mem[m_front][row * COLS + col];
            lo = m_mem[m_front][(SCAN_ROWS + row) * COLS + col];
            rd = {pbit(lo, 0, p), pbit(up, 0, p)};
            gr = {pbit(lo, 1, p), pbit(up, 1, p)};
            bl = {pbit(lo, 2, p), pbit(up, 2, p)};
        end else if (r == 2 * COLS) begin
            la = 1'b1;
        end else begin
            bk = 1'b0;
        end
        ra = (p == 0 && r < 2 * COLS) ? ((m_t < 2 * COLS) ? 2'd0 : 2'((row + SCAN_ROWS - 1) % SCAN_ROWS)) : 2'(row);
        return {rd, gr, bl, sc, la, bk, ra, !m_pend, m_done};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== RST_OUT) $display("FAIL reset_values got %b want %b", obs, RST_OUT);
        else passed++;
        reset = 1'b1;
        for (int i = 0; i < 45; i++) begin
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL reset_scan t=%0d got %b want %b", m_t, obs, exp_v);
            else passed++;
            if (i >= 31 && i <= 41) begin
                total++;
                if ({latch, blank} !== {i == 32, !(i >= 33 && i <= 40)})
                    $display("FAIL first_latch cycle=%0d got latch=%b blank=%b want latch=%b blank=%b",
                             i, latch, blank, i == 32, !(i >= 33 && i <= 40));
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pixel(input string name, input logic [6:0] addr, input logic [PIX_W-1:0] data);
        int cnt [6];
        int want [6];
        bit seen = 0;
        for (int c = 0; c < 3; c++)
            for (int h = 0; h < 2; h++) begin
                cnt[c * 2 + h] = 0;
                want[c * 2 + h] = (h == int'(addr[6])) ? 2 * $countones((int'(data) >> ((2 - c) * BPC)) & ((1 << BPC) - 1)) : 0;
            end
        wr_valid = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_valid = 1'b0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        for (int i = 0; i < FRAME + 5 && !seen; i++) begin
            @(negedge clk);
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL %s_wait t=%0d got %b want %b", name, m_t, obs, exp_v);
            else passed++;
            seen = swap_done;
        end
        total++;
        if (!seen) $display("FAIL %s_swap_done got none want pulse within %0d cycles", name, FRAME + 5);
        else passed++;
        for (int i = 0; i < FRAME; i++) begin
            cnt[0] += int'(red[0]);
            cnt[1] += int'(red[1]);
            cnt[2] += int'(green[0]);
            cnt[3] += int'(green[1]);
            cnt[4] += int'(blue[0]);
            cnt[5] += int'(blue[1]);
            @(negedge clk);
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL %s_scan t=%0d got %b want %b", name, m_t, obs, exp_v);
            else passed++;
        end
        for (int j = 0; j < 6; j++) begin
            total++;
            if (cnt[j] != want[j]) $display("FAIL %s_lit[%0d] got %0d want %0d", name, j, cnt[j], want[j]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        swap_req = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            wr_addr = 7'($urandom);
            wr_data = PIX_W'($urandom);
            @(negedge clk);
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL b2b_hold t=%0d got %b want %b", m_t, obs, exp_v);
            else passed++;
            if (i == 0) begin
                total++;
                if (wr_ready !== 1'b0) $display("FAIL b2b_stall got wr_ready=%b want 0", wr_ready);
                else passed++;
            end
        end
        swap_req = 1'b0;
        wr_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL b2b_scan t=%0d got %b want %b", m_t, obs, exp_v);
            else passed++;
        end
    endtask

    task automatic test_bcm_duty();
        int lows = 0;
        int lat = 0;
        logic [15:0] seq = '0;
        bit ok = 0;
        for (int i = 0; i < FRAME + 1 && !ok; i++) begin
            if (m_t % FRAME == 0) ok = 1;
            else @(negedge clk);
        end
        total++;
        if (!ok) $display("FAIL duty_align got no frame start want one within %0d cycles", FRAME + 1);
        else passed++;
        for (int i = 0; i < FRAME; i++) begin
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL duty_scan t=%0d got %b want %b", m_t, obs, exp_v);
            else passed++;
            lows += int'(!blank);
            if (latch) begin
                lat++;
                seq = {seq[13:0], row_addr};
            end
            @(negedge clk);
        end
        total++;
        if (lows != SCAN_ROWS * BASE_ON * ((1 << BPC) - 1)) $display("FAIL duty_dark got %0d want %0d", lows, SCAN_ROWS * BASE_ON * ((1 << BPC) - 1));
        else passed++;
        total++;
        if (lat != SCAN_ROWS * BPC) $display("FAIL duty_latches got %0d want %0d", lat, SCAN_ROWS * BPC);
        else passed++;
        total++;
        if (seq !== 16'h05AF) $display("FAIL duty_rows got %h want 05af", seq);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int lit = 0;
        bit seen = 0;
        bit ok = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wr_addr = 7'($urandom);
            wr_data = PIX_W'($urandom) | PIX_W'(6'b100001);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        for (int i = 0; i < FRAME + 5 && !seen; i++) begin
            @(negedge clk);
            seen = swap_done;
        end
        total++;
        if (!seen) $display("FAIL mid_swap_done got none want pulse within %0d cycles", FRAME + 5);
        else passed++;
        for (int i = 0; i < FRAME + 1 && !ok; i++) begin
            if (m_t % FRAME == 170) ok = 1;
            else @(negedge clk);
        end
        total++;
        if (!ok || blank !== 1'b0) $display("FAIL mid_display got aligned=%0d blank=%b want aligned=1 blank=0", ok, blank);
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs !== RST_OUT) $display("FAIL async_reset got %b want %b", obs, RST_OUT);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            exp_v = exp_out();
            total++;
            if (obs !== exp_v) $display("FAIL mid_restart t=%0d got %b want %b", m_t, obs, exp_v);
            else passed++;
            lit += int'(|{red, green, blue});
            @(negedge clk);
        end
        total++;
        if (lit != 0) $display("FAIL mid_dark got %0d lit cycles want 0", lit);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_pixel("full_red", 7'd5, 6'b110000);
        test_pixel("lower_blue", 7'b1111111, 6'b000001);
        test_back_to_back();
        test_bcm_duty();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
